// File: rtl/idecoder_pipe.sv
// RV32I/M decode stage: combinational decode on the fetch side, results
// written into a small FIFO so the execute side only sees registered data.
module idecoder_pipe #(
   parameter int inst_width      = 32,
   parameter int pc_width        = 32,
   parameter int reg_width       = 5,
   parameter int funct_width     = 5,
   parameter int inst_type_width = 4,
   parameter int depth           = 2,
   parameter int enable_m        = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       inst_valid,
   output logic                       inst_ready,
   input  logic [inst_width-1:0]      inst,
   input  logic [pc_width-1:0]        pc,
   output logic                       dec_valid,
   input  logic                       dec_ready,
   output logic [pc_width-1:0]        dec_pc,
   output logic [inst_width-1:0]      imm,
   output logic [inst_type_width-1:0] inst_type,
   output logic [reg_width-1:0]       rd,
   output logic [reg_width-1:0]       rs1,
   output logic [reg_width-1:0]       rs2,
   output logic [funct_width-1:0]     funct,
   output logic                       illegal,
   output logic [31:0]                dec_count
);

   // shared project codes
   localparam logic [inst_type_width-1:0] inst_type_imm    = inst_type_width'(0);
   localparam logic [inst_type_width-1:0] inst_type_reg    = inst_type_width'(1);
   localparam logic [inst_type_width-1:0] inst_type_lui    = inst_type_width'(2);
   localparam logic [inst_type_width-1:0] inst_type_auipc  = inst_type_width'(3);
   localparam logic [inst_type_width-1:0] inst_type_jal    = inst_type_width'(4);
   localparam logic [inst_type_width-1:0] inst_type_jalr   = inst_type_width'(5);
   localparam logic [inst_type_width-1:0] inst_type_branch = inst_type_width'(6);
   localparam logic [inst_type_width-1:0] inst_type_load   = inst_type_width'(7);
   localparam logic [inst_type_width-1:0] inst_type_store  = inst_type_width'(8);
   localparam logic [inst_type_width-1:0] inst_type_fence  = inst_type_width'(9);

   localparam logic [funct_width-1:0] funct_add       = funct_width'(0);
   localparam logic [funct_width-1:0] funct_sub       = funct_width'(1);
   localparam logic [funct_width-1:0] funct_sll       = funct_width'(2);
   localparam logic [funct_width-1:0] funct_slt       = funct_width'(3);
   localparam logic [funct_width-1:0] funct_sltu      = funct_width'(4);
   localparam logic [funct_width-1:0] funct_xor       = funct_width'(5);
   localparam logic [funct_width-1:0] funct_srl       = funct_width'(6);
   localparam logic [funct_width-1:0] funct_sra       = funct_width'(7);
   localparam logic [funct_width-1:0] funct_or        = funct_width'(8);
   localparam logic [funct_width-1:0] funct_and       = funct_width'(9);
   localparam logic [funct_width-1:0] funct_beq       = funct_width'(10);
   localparam logic [funct_width-1:0] funct_bne       = funct_width'(11);
   localparam logic [funct_width-1:0] funct_blt       = funct_width'(12);
   localparam logic [funct_width-1:0] funct_bge       = funct_width'(13);
   localparam logic [funct_width-1:0] funct_bltu      = funct_width'(14);
   localparam logic [funct_width-1:0] funct_bgeu      = funct_width'(15);
   localparam logic [funct_width-1:0] funct_mem_byte  = funct_width'(16);
   localparam logic [funct_width-1:0] funct_mem_hword = funct_width'(17);
   localparam logic [funct_width-1:0] funct_mem_word  = funct_width'(18);
   localparam logic [funct_width-1:0] funct_mem_byteu = funct_width'(19);
   localparam logic [funct_width-1:0] funct_mem_hwordu= funct_width'(20);
   localparam logic [funct_width-1:0] funct_mul       = funct_width'(22);

   localparam int          AW     = $clog2(depth);
   localparam int          PW     = AW + 1;
   localparam int unsigned DEPTHU = depth;
   localparam int          EW     = pc_width + inst_width + inst_type_width
                                    + 3*reg_width + funct_width + 1;

   logic [6:0]                 w_opcode;
   logic [2:0]                 w_funct3;
   logic [6:0]                 w_funct7;
   logic [inst_width-1:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
   logic                       w_ok;
   logic [inst_width-1:0]      w_imm;
   logic [inst_type_width-1:0] w_type;
   logic [reg_width-1:0]       w_rd, w_rs1, w_rs2;
   logic [funct_width-1:0]     w_funct;
   logic                       w_illegal;

   assign w_opcode = inst[6:0];
   assign w_funct3 = inst[14:12];
   assign w_funct7 = inst[31:25];
   assign w_imm_i  = {{(inst_width-12){inst[31]}}, inst[31:20]};
   assign w_imm_s  = {{(inst_width-12){inst[31]}}, inst[31:25], inst[11:7]};
   assign w_imm_b  = {{(inst_width-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign w_imm_u  = {inst[31:12], 12'b0};
   assign w_imm_j  = {{(inst_width-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign w_imm_sh = {{(inst_width-5){1'b0}}, inst[24:20]};

   // decode the incoming word; anything unrecognised collapses to an all-zero illegal entry
   always_comb begin
      w_ok    = 1'b0;
      w_imm   = '0;
      w_type  = '0;
      w_rd    = '0;
      w_rs1   = '0;
      w_rs2   = '0;
      w_funct = funct_add;
      case (w_opcode)
         7'b0110111: begin
            w_ok = 1'b1; w_type = inst_type_lui; w_imm = w_imm_u; w_rd = reg_width'(inst[11:7]);
         end
         7'b0010111: begin
            w_ok = 1'b1; w_type = inst_type_auipc; w_imm = w_imm_u; w_rd = reg_width'(inst[11:7]);
         end
         7'b1101111: begin
            w_ok = 1'b1; w_type = inst_type_jal; w_imm = w_imm_j; w_rd = reg_width'(inst[11:7]);
         end
         7'b1100111: begin
            w_ok = (w_funct3 == 3'd0); w_type = inst_type_jalr; w_imm = w_imm_i;
            w_rd = reg_width'(inst[11:7]); w_rs1 = reg_width'(inst[19:15]);
         end
         7'b1100011: begin
            w_ok = 1'b1; w_type = inst_type_branch; w_imm = w_imm_b;
            w_rs1 = reg_width'(inst[19:15]); w_rs2 = reg_width'(inst[24:20]);
            case (w_funct3)
               3'd0: w_funct = funct_beq;
               3'd1: w_funct = funct_bne;
               3'd4: w_funct = funct_blt;
               3'd5: w_funct = funct_bge;
               3'd6: w_funct = funct_bltu;
               3'd7: w_funct = funct_bgeu;
               default: w_ok = 1'b0;
            endcase
         end
         7'b0000011: begin
            w_ok = 1'b1; w_type = inst_type_load; w_imm = w_imm_i;
            w_rd = reg_width'(inst[11:7]); w_rs1 = reg_width'(inst[19:15]);
            case (w_funct3)
               3'd0: w_funct = funct_mem_byte;
               3'd1: w_funct = funct_mem_hword;
               3'd2: w_funct = funct_mem_word;
               3'd4: w_funct = funct_mem_byteu;
               3'd5: w_funct = funct_mem_hwordu;
               default: w_ok = 1'b0;
            endcase
         end
         7'b0100011: begin
            w_ok = 1'b1; w_type = inst_type_store; w_imm = w_imm_s;
            w_rs1 = reg_width'(inst[19:15]); w_rs2 = reg_width'(inst[24:20]);
            case (w_funct3)
               3'd0: w_funct = funct_mem_byte;
               3'd1: w_funct = funct_mem_hword;
               3'd2: w_funct = funct_mem_word;
               default: w_ok = 1'b0;
            endcase
         end
         7'b0010011: begin
            w_ok = 1'b1; w_type = inst_type_imm; w_imm = w_imm_i;
            w_rd = reg_width'(inst[11:7]); w_rs1 = reg_width'(inst[19:15]);
            case (w_funct3)
               3'd0: w_funct = funct_add;
               3'd2: w_funct = funct_slt;
               3'd3: w_funct = funct_sltu;
               3'd4: w_funct = funct_xor;
               3'd6: w_funct = funct_or;
               3'd7: w_funct = funct_and;
               3'd1: begin
                  w_funct = funct_sll; w_imm = w_imm_sh; w_ok = (w_funct7 == 7'b0000000);
               end
               default: begin
                  w_imm = w_imm_sh;
                  if (w_funct7 == 7'b0000000)      w_funct = funct_srl;
                  else if (w_funct7 == 7'b0100000) w_funct = funct_sra;
                  else                             w_ok = 1'b0;
               end
            endcase
         end
         7'b0110011: begin
            w_type = inst_type_reg;
            w_rd = reg_width'(inst[11:7]); w_rs1 = reg_width'(inst[19:15]); w_rs2 = reg_width'(inst[24:20]);
            if (w_funct7 == 7'b0000000) begin
               w_ok = 1'b1;
               case (w_funct3)
                  3'd0: w_funct = funct_add;
                  3'd1: w_funct = funct_sll;
                  3'd2: w_funct = funct_slt;
                  3'd3: w_funct = funct_sltu;
                  3'd4: w_funct = funct_xor;
                  3'd5: w_funct = funct_srl;
                  3'd6: w_funct = funct_or;
                  default: w_funct = funct_and;
               endcase
            end else if (w_funct7 == 7'b0100000) begin
               if (w_funct3 == 3'd0) begin
                  w_ok = 1'b1; w_funct = funct_sub;
               end else if (w_funct3 == 3'd5) begin
                  w_ok = 1'b1; w_funct = funct_sra;
               end
            end else if (enable_m != 0 && w_funct7 == 7'b0000001) begin
               w_ok = 1'b1; w_funct = funct_mul + funct_width'(w_funct3);
            end
         end
         7'b0001111: begin
            w_ok = (w_funct3 == 3'd0); w_type = inst_type_fence;
         end
         default: w_ok = 1'b0;
      endcase
      if (inst[1:0] != 2'b11) w_ok = 1'b0;
      if (!w_ok) begin
         w_imm = '0; w_type = '0; w_rd = '0; w_rs1 = '0; w_rs2 = '0; w_funct = '0;
      end
      w_illegal = !w_ok;
   end

   logic [EW-1:0] r_mem [depth];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [31:0]   r_count;
   logic          w_full, w_empty, w_push, w_pop;
   logic [EW-1:0] w_wr_entry;

   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign inst_ready = !rst && !w_full;
   assign dec_valid  = !rst && !w_empty;
   assign w_push     = inst_valid && inst_ready;
   assign w_pop      = dec_valid && dec_ready;
   assign w_wr_entry = {pc, w_imm, w_type, w_rd, w_rs1, w_rs2, w_funct, w_illegal};
   assign {dec_pc, imm, inst_type, rd, rs1, rs2, funct, illegal} = r_mem[r_rd_ptr[AW-1:0]];
   assign dec_count  = r_count;

   // FIFO pointers, storage and pop counter; reset beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTHU; i++) r_mem[AW'(i)] <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count  <= r_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_idecoder_pipe.sv
// Bench for idecoder_pipe: two instances (M off / M on) share stimulus and are
// compared every cycle against an ISA-level decode model and a queue model.
module tb_idecoder_pipe;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] imm;
      logic [3:0]  typ;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  fn;
      logic        ill;
   } dec_t;

   typedef struct {
      logic [31:0] w;
      logic [31:0] pc;
   } ent_t;

   localparam int ALU_FN [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
   localparam int BR_FN  [8] = '{10, 11, -1, -1, 12, 13, 14, 15};

   logic clk, rst, flush, inst_valid, dec_ready;
   logic [31:0] inst, pc;

   logic        d0_ready, d0_valid, d0_ill, d1_ready, d1_valid, d1_ill;
   logic [31:0] d0_pc, d0_imm, d0_count, d1_pc, d1_imm, d1_count;
   logic [3:0]  d0_type, d1_type;
   logic [4:0]  d0_rd, d0_rs1, d0_rs2, d0_fn, d1_rd, d1_rs1, d1_rs2, d1_fn;

   idecoder_pipe #(.depth(DEPTH), .enable_m(0)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid), .inst_ready(d0_ready),
      .inst(inst), .pc(pc), .dec_valid(d0_valid), .dec_ready(dec_ready), .dec_pc(d0_pc),
      .imm(d0_imm), .inst_type(d0_type), .rd(d0_rd), .rs1(d0_rs1), .rs2(d0_rs2),
      .funct(d0_fn), .illegal(d0_ill), .dec_count(d0_count));

   idecoder_pipe #(.depth(DEPTH), .enable_m(1)) u_dut_m (
      .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid), .inst_ready(d1_ready),
      .inst(inst), .pc(pc), .dec_valid(d1_valid), .dec_ready(dec_ready), .dec_pc(d1_pc),
      .imm(d1_imm), .inst_type(d1_type), .rd(d1_rd), .rs1(d1_rs1), .rs2(d1_rs2),
      .funct(d1_fn), .illegal(d1_ill), .dec_count(d1_count));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
   endtask

   // ISA-level reference decode
   function automatic dec_t model(input logic [31:0] w, input bit m);
      dec_t d;
      int   f3, f7, v;
      bit   ok;
      d  = '0;
      ok = 1'b1;
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      case (w[6:0])
         7'h37, 7'h17: begin
            d.typ = (w[6:0] == 7'h37) ? 4'd2 : 4'd3;
            d.imm = w & 32'hFFFF_F000; d.rd = w[11:7];
         end
         7'h6F: begin
            v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            d.typ = 4'd4; d.imm = v; d.rd = w[11:7];
         end
         7'h67: begin
            ok = (f3 == 0); d.typ = 4'd5; d.imm = $signed(w) >>> 20; d.rd = w[11:7]; d.rs1 = w[19:15];
         end
         7'h63: begin
            v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            ok = (BR_FN[f3] >= 0); d.fn = 5'(BR_FN[f3]);
            d.typ = 4'd6; d.imm = v; d.rs1 = w[19:15]; d.rs2 = w[24:20];
         end
         7'h03: begin
            ok = (f3 != 3 && f3 < 6); d.fn = 5'(16 + (f3 < 4 ? f3 : f3 - 1));
            d.typ = 4'd7; d.imm = $signed(w) >>> 20; d.rd = w[11:7]; d.rs1 = w[19:15];
         end
         7'h23: begin
            ok = (f3 < 3); d.fn = 5'(16 + f3); d.typ = 4'd8;
            d.imm = ((32'($signed(w) >>> 20)) & 32'hFFFF_FFE0) | 32'(w[11:7]);
            d.rs1 = w[19:15]; d.rs2 = w[24:20];
         end
         7'h13: begin
            d.typ = 4'd0; d.rd = w[11:7]; d.rs1 = w[19:15]; d.fn = 5'(ALU_FN[f3]);
            if (f3 == 1 || f3 == 5) begin
               d.imm = 32'(w[24:20]);
               ok = (f7 == 0) || (f3 == 5 && f7 == 32);
               if (f3 == 5 && f7 == 32) d.fn = 5'd7;
            end else d.imm = $signed(w) >>> 20;
         end
         7'h33: begin
            d.typ = 4'd1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
            if (f7 == 0) d.fn = 5'(ALU_FN[f3]);
            else if (f7 == 32 && f3 == 0) d.fn = 5'd1;
            else if (f7 == 32 && f3 == 5) d.fn = 5'd7;
            else if (f7 == 1 && m) d.fn = 5'(22 + f3);
            else ok = 1'b0;
         end
         7'h0F: begin
            ok = (f3 == 0); d.typ = 4'd9;
         end
         default: ok = 1'b0;
      endcase
      if (w[1:0] != 2'b11) ok = 1'b0;
      if (!ok) d = '0;
      d.ill = !ok;
      return d;
   endfunction

   ent_t        q[$];
   int unsigned m_cnt = 0;
   bit          m_clr = 1'b0;
   bit          started = 1'b0;
   bit          m_push, m_pop;

   // reference FIFO state, advanced on each rising edge from the inputs in force
   always @(posedge clk) begin
      if (rst) begin
         q.delete(); m_cnt = 0; m_clr = 1'b1; started = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         m_push = inst_valid && (q.size() < DEPTH);
         m_pop  = (q.size() > 0) && dec_ready;
         if (m_pop) begin
            void'(q.pop_front());
            m_cnt++;
         end
         if (m_push) begin
            q.push_back('{w: inst, pc: pc});
            m_clr = 1'b0;
         end
      end
   end

   // every-cycle comparison of both instances against the reference
   always @(negedge clk) begin
      if (started) begin
         bit   ev;
         dec_t e0, e1;
         ev = !rst && (q.size() > 0);
         chk("inst_ready",   d0_ready, !rst && (q.size() < DEPTH));
         chk("inst_ready_m", d1_ready, !rst && (q.size() < DEPTH));
         chk("dec_valid",    d0_valid, ev);
         chk("dec_valid_m",  d1_valid, ev);
         chk("dec_count",    d0_count, m_cnt);
         chk("dec_count_m",  d1_count, m_cnt);
         if (ev) begin
            e0 = model(q[0].w, 1'b0);
            e1 = model(q[0].w, 1'b1);
            chk("head", {d0_pc, d0_imm, d0_type, d0_rd, d0_rs1, d0_rs2, d0_fn, d0_ill}, {q[0].pc, e0});
            chk("head_m", {d1_pc, d1_imm, d1_type, d1_rd, d1_rs1, d1_rs2, d1_fn, d1_ill}, {q[0].pc, e1});
         end else if (m_clr) begin
            chk("cleared",   {d0_pc, d0_imm, d0_type, d0_rd, d0_rs1, d0_rs2, d0_fn, d0_ill}, '0);
            chk("cleared_m", {d1_pc, d1_imm, d1_type, d1_rd, d1_rs1, d1_rs2, d1_fn, d1_ill}, '0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addi(input int k);
      return (32'(k) << 20) | 32'h0000_0093;
   endfunction

   logic [31:0] vec [16];
   logic [31:0] c0;
   bit          acc;

   initial begin
      vec = '{32'h00512423, 32'hFE208EE3, 32'hFFC12083, 32'h02B50533, 32'h00000073,
              32'h00000001, 32'h0FF0000F, 32'h00001097, 32'h000080E7, 32'h00414083,
              32'h0020A063, 32'h00351513, 32'h02351513, 32'h00B56533, 32'h0000100F,
              32'h80000537};

      // reset held with a pending instruction
      rst = 1'b1; flush = 1'b0; inst_valid = 1'b1; inst = 32'h12345537; pc = 32'h100; dec_ready = 1'b0;
      repeat (3) begin
         step();
         chk("rst_valid", d0_valid, 1'b0);
         chk("rst_ready", d0_ready, 1'b0);
         chk("rst_fields", {d0_pc, d0_imm, d0_type, d0_rd, d0_rs1, d0_rs2, d0_fn, d0_ill}, '0);
      end
      rst = 1'b0; inst_valid = 1'b0;
      #1;
      chk("ready_after_rst", d0_ready, 1'b1);

      // back-to-back stream, one per cycle
      dec_ready = 1'b1; inst_valid = 1'b1;
      inst = 32'h12345537; pc = 32'h1000; step();
      chk("lui_imm", d0_imm, 32'h12345000);
      chk("lui_rd", d0_rd, 5'd10);
      inst = 32'h008000EF; pc = 32'h1004; step();
      chk("jal_imm", d0_imm, 32'd8);
      chk("jal_rd", d0_rd, 5'd1);
      chk("jal_pc", d0_pc, 32'h1004);
      inst = 32'h40B50533; pc = 32'h1008; step();
      chk("sub_funct", d0_fn, 5'd1);
      chk("sub_regs", {d0_rs1, d0_rs2, d0_rd}, {5'd10, 5'd11, 5'd10});
      inst_valid = 1'b0; step();
      chk("stream_count", d0_count, 32'd3);

      // backpressure: depth+1 pushes with the consumer stalled
      dec_ready = 1'b0; inst_valid = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         inst = addi(k); pc = 32'h2000 + 32'(4 * k); step();
      end
      chk("full_ready", d0_ready, 1'b0);
      chk("full_head", d0_imm, 32'd1);
      inst = addi(DEPTH + 1); step();
      chk("stall_head", d0_imm, 32'd1);
      dec_ready = 1'b1; step();
      chk("freed_ready", d0_ready, 1'b1);
      chk("next_head", d0_imm, 32'd2);
      step();
      inst_valid = 1'b0;
      for (int k = 3; k <= DEPTH + 1; k++) begin
         chk("drain_order", d0_imm, 32'(k));
         step();
      end
      chk("drained", d0_valid, 1'b0);

      // illegal and M-extension decode; funct3=4 selects div
      inst_valid = 1'b1; inst = 32'h02A5C533; step();
      chk("div_noM_ill", {d0_ill, d0_fn}, {1'b1, 5'd0});
      chk("div_M", {d1_ill, d1_fn, d1_rd, d1_rs1, d1_rs2}, {1'b0, 5'd26, 5'd10, 5'd11, 5'd10});
      inst = 32'hFFFFFFFF; step();
      chk("ones_ill", {d0_ill, d1_ill, d0_imm, d0_type}, {2'b11, 32'd0, 4'd0});
      inst = 32'h41F55513; step();
      chk("srai", {d0_ill, d0_fn, d0_imm}, {1'b0, 5'd7, 32'd31});
      inst = 32'h7E055513; step();
      chk("bad_shift_ill", d0_ill, 1'b1);
      inst_valid = 1'b0; step();

      // flush with a concurrent push and pop
      dec_ready = 1'b0; inst_valid = 1'b1;
      inst = addi(7); step();
      inst = addi(8); step();
      c0 = d0_count;
      chk("pre_flush_valid", d0_valid, 1'b1);
      flush = 1'b1; inst = addi(9); dec_ready = 1'b1; step();
      flush = 1'b0; inst_valid = 1'b0; dec_ready = 1'b0;
      chk("flush_empty", d0_valid, 1'b0);
      chk("flush_count", d0_count, c0);
      step();
      chk("flush_dropped", d0_valid, 1'b0);

      // mixed vectors with random backpressure
      inst_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         inst = vec[i]; pc = 32'h3000 + 32'(4 * i);
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) begin
            dec_ready = 1'($urandom_range(0, 1));
            acc = d0_ready;
            step();
         end
         if (!acc) chk("push_timeout", acc, 1'b1);
      end
      inst_valid = 1'b0; dec_ready = 1'b1;
      repeat (DEPTH + 2) step();
      chk("vec_drained", d0_valid, 1'b0);

      // reset mid-stream
      dec_ready = 1'b0; inst_valid = 1'b1; inst = addi(10); step();
      inst_valid = 1'b0; rst = 1'b1; step();
      rst = 1'b0;
      #1;
      chk("midrst_valid", d0_valid, 1'b0);
      chk("midrst_count", d0_count, 32'd0);
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
